// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Package     : traffic_pkg
// Description : Lamp code constants, phase and error classes, and small decode
//               helpers shared by the traffic lamp driver and its monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Car lamp codes, bit order {red, yellow, green, left_arrow}
  localparam logic [3:0] CAR_RED        = 4'b1000;
  localparam logic [3:0] CAR_RED_LEFT   = 4'b1001;
  localparam logic [3:0] CAR_GREEN      = 4'b0010;
  localparam logic [3:0] CAR_GREEN_LEFT = 4'b0011;
  localparam logic [3:0] CAR_YELLOW     = 4'b0100;

  // Walk lamp codes, bit order {walk_red, walk_green}
  localparam logic [1:0] WALK_STOP = 2'b10;
  localparam logic [1:0] WALK_GO   = 2'b01;

  typedef enum logic [1:0] {
    PH_RED     = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2,
    PH_UNKNOWN = 2'd3
  } phase_id_e;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_ILLEGAL_CAR  = 3'd1,
    ERR_ILLEGAL_WALK = 3'd2,
    ERR_CONFLICT     = 3'd3,
    ERR_SEQ          = 3'd4,
    ERR_YEL_SHORT    = 3'd5,
    ERR_YEL_LONG     = 3'd6
  } err_code_e;

  // Class of a car lamp code; left-arrow variants share their base class.
  function automatic phase_id_e car_class(input logic [3:0] car);
    case (car)
      CAR_RED, CAR_RED_LEFT:     car_class = PH_RED;
      CAR_GREEN, CAR_GREEN_LEFT: car_class = PH_GREEN;
      CAR_YELLOW:                car_class = PH_YELLOW;
      default:                   car_class = PH_UNKNOWN;
    endcase
  endfunction

  function automatic logic walk_legal(input logic [1:0] walk);
    walk_legal = (walk == WALK_STOP) || (walk == WALK_GO);
  endfunction

  // Only the RED -> GREEN -> YELLOW -> RED rotation is a legal class change.
  function automatic logic seq_legal(input phase_id_e from_cls, input phase_id_e to_cls);
    seq_legal = ((from_cls == PH_RED)    && (to_cls == PH_GREEN))  ||
                ((from_cls == PH_GREEN)  && (to_cls == PH_YELLOW)) ||
                ((from_cls == PH_YELLOW) && (to_cls == PH_RED));
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_signal_monitor_if.sv
`default_nettype none
// ============================================================================
// Interface   : traffic_signal_monitor_if
// Description : Lamp bus seen by the monitor plus the monitor's report bus.
//               master : lamp driver / board fault logic side
//               slave  : traffic_signal_monitor side
// Signals     : path_index[1:0], car_traffic[3:0], walk_traffic[1:0],
//               clear_fault            (master -> slave)
//               phase_done, phase_id[1:0], phase_len[CNT_W-1:0], err_valid,
//               err_code[2:0], err_count[7:0], fault   (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_signal_monitor_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       path_index;
  logic [3:0]       car_traffic;
  logic [1:0]       walk_traffic;
  logic             clear_fault;
  logic             phase_done;
  logic [1:0]       phase_id;
  logic [CNT_W-1:0] phase_len;
  logic             err_valid;
  logic [2:0]       err_code;
  logic [7:0]       err_count;
  logic             fault;

  modport master (
    output path_index, car_traffic, walk_traffic, clear_fault,
    input  phase_done, phase_id, phase_len, err_valid, err_code, err_count, fault
  );

  modport slave (
    input  path_index, car_traffic, walk_traffic, clear_fault,
    output phase_done, phase_id, phase_len, err_valid, err_code, err_count, fault
  );
endinterface
`default_nettype wire

// File: rtl/traffic_signal_monitor_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Saturating cycle counter with synchronous clear and enable.
//               Clear has priority over enable.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               i_clr      - restart count at 0
//               i_en       - count one cycle
//               o_cnt      - current count, sticks at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_clr,
  input  wire logic             i_en,
  output logic      [CNT_W-1:0] o_cnt
);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
endmodule
`default_nettype wire

// File: rtl/traffic_signal_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_signal_monitor
// Description : Passive checker on one approach of the lamp bus. Registers the
//               lamp codes once, checks code legality, car/walk conflicts,
//               phase order and yellow duration, and reports phase lengths and
//               errors one cycle after the registered sample.
// Ports       : clk, rst - clock, synchronous active-high reset
//               bus      - traffic_signal_monitor_if.slave (lamp inputs,
//                          clear_fault, phase and error reports, fault)
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_signal_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MIN_YELLOW = 3,
  parameter int MAX_YELLOW = 20,
  parameter int EXP_PATH   = 0
) (
  input wire logic                clk,
  input wire logic                rst,
  traffic_signal_monitor_if.slave bus
);
  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_RED    = 3'd1;
  localparam logic [2:0] S_GREEN  = 3'd2;
  localparam logic [2:0] S_YELLOW = 3'd3;
  localparam logic [2:0] S_BAD    = 3'd4;

  localparam logic [1:0]       c_exp_path = 2'(EXP_PATH);
  localparam logic [CNT_W-1:0] c_min_yel  = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] c_max_yel  = CNT_W'(MAX_YELLOW);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  // Stage S: registered lamp bus. r_s_vld keeps the all-zero reset contents
  // of the stage from being judged as an illegal code.
  logic [1:0] r_path;
  logic [3:0] r_car;
  logic [1:0] r_walk;
  logic       r_s_vld;

  logic [2:0]       r_state;
  logic             r_phase_done;
  logic [1:0]       r_phase_id;
  logic [CNT_W-1:0] r_phase_len;
  logic             r_err_valid;
  logic [2:0]       r_err_code;
  logic [7:0]       r_err_count;
  logic             r_fault;

  phase_id_e        w_car_cls, w_cls, w_cur_cls;
  err_code_e        w_code;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_timer, w_len;
  logic w_walk_ok, w_samp, w_enter, w_change;
  logic w_conflict, w_ill_car, w_ill_walk, w_seq, w_yshort, w_ylong, w_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_path  <= '0;
      r_car   <= '0;
      r_walk  <= '0;
      r_s_vld <= 1'b0;
    end else begin
      r_path  <= bus.path_index;
      r_car   <= bus.car_traffic;
      r_walk  <= bus.walk_traffic;
      r_s_vld <= 1'b1;
    end
  end

  // Either lamp group being illegal puts the sample in the UNKNOWN class.
  assign w_car_cls = car_class(r_car);
  assign w_walk_ok = walk_legal(r_walk);
  assign w_cls     = (!w_walk_ok) ? PH_UNKNOWN : w_car_cls;
  assign w_samp    = r_s_vld && (r_path == c_exp_path);

  always_comb begin
    w_cur_cls   = PH_UNKNOWN;
    w_state_nxt = S_BAD;
    case (r_state)
      S_RED:    w_cur_cls = PH_RED;
      S_GREEN:  w_cur_cls = PH_GREEN;
      S_YELLOW: w_cur_cls = PH_YELLOW;
      default:  w_cur_cls = PH_UNKNOWN;
    endcase
    case (w_cls)
      PH_RED:    w_state_nxt = S_RED;
      PH_GREEN:  w_state_nxt = S_GREEN;
      PH_YELLOW: w_state_nxt = S_YELLOW;
      default:   w_state_nxt = S_BAD;
    endcase
  end

  // w_enter loads a new class (including the first one out of S_INIT);
  // w_change is the subset that closes a measured phase.
  assign w_enter  = w_samp && ((r_state == S_INIT) || (w_cls != w_cur_cls));
  assign w_change = w_enter && (r_state != S_INIT);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_enter),
    .i_en  (w_samp && !w_enter),
    .o_cnt (w_timer)
  );

  // The timer lags the class by one cycle, so timer+1 is the length of the
  // phase up to the previous sample; at a class change that is the full
  // length of the phase that just ended.
  assign w_len = (w_timer == c_cnt_max) ? w_timer : (w_timer + CNT_W'(1));

  assign w_conflict = w_samp && r_walk[0] && (w_car_cls != PH_RED);
  assign w_ill_car  = w_samp && (w_car_cls == PH_UNKNOWN);
  assign w_ill_walk = w_samp && !w_walk_ok;
  assign w_seq      = w_change && (w_cls != PH_UNKNOWN) && (w_cur_cls != PH_UNKNOWN) &&
                      !seq_legal(w_cur_cls, w_cls);
  assign w_yshort   = w_change && (r_state == S_YELLOW) && (w_len < c_min_yel);
  // Yellow cycles including the current one are w_len+1, so equality with
  // MAX_YELLOW flags the first cycle beyond the limit, exactly once.
  assign w_ylong    = w_samp && (r_state == S_YELLOW) && (w_cls == PH_YELLOW) &&
                      (w_len == c_max_yel);
  assign w_err      = w_conflict || w_ill_car || w_ill_walk || w_seq || w_yshort || w_ylong;

  always_comb begin
    w_code = ERR_NONE;
    if (w_conflict)      w_code = ERR_CONFLICT;
    else if (w_ill_car)  w_code = ERR_ILLEGAL_CAR;
    else if (w_ill_walk) w_code = ERR_ILLEGAL_WALK;
    else if (w_seq)      w_code = ERR_SEQ;
    else if (w_yshort)   w_code = ERR_YEL_SHORT;
    else if (w_ylong)    w_code = ERR_YEL_LONG;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_INIT;
      r_phase_done <= 1'b0;
      r_phase_id   <= '0;
      r_phase_len  <= '0;
      r_err_valid  <= 1'b0;
      r_err_code   <= '0;
      r_err_count  <= '0;
      r_fault      <= 1'b0;
    end else begin
      if (w_enter) begin
        r_state <= w_state_nxt;
      end
      r_phase_done <= w_change;
      r_phase_id   <= w_change ? w_cur_cls : 2'd0;
      r_phase_len  <= w_change ? w_len : '0;
      r_err_valid  <= w_err;
      r_err_code   <= w_code;
      // A new error outranks a simultaneous clear: it is the first error
      // counted after the clear.
      if (w_err) begin
        r_fault <= 1'b1;
        if (bus.clear_fault)            r_err_count <= 8'd1;
        else if (r_err_count != 8'hFF)  r_err_count <= r_err_count + 8'd1;
      end else if (bus.clear_fault) begin
        r_fault     <= 1'b0;
        r_err_count <= '0;
      end
    end
  end

  assign bus.phase_done = r_phase_done;
  assign bus.phase_id   = r_phase_id;
  assign bus.phase_len  = r_phase_len;
  assign bus.err_valid  = r_err_valid;
  assign bus.err_code   = r_err_code;
  assign bus.err_count  = r_err_count;
  assign bus.fault      = r_fault;
endmodule
`default_nettype wire

// File: tb/tb_traffic_signal_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_signal_monitor
// Description : Directed bench for traffic_signal_monitor. Expected phase and
//               error pulses are queued when the stimulus is driven and
//               compared on the falling edge when they fall due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_signal_monitor;
  import traffic_pkg::*;

  localparam int c_cnt_w = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;
  logic chk_en = 1'b0;

  typedef struct { int due; logic [1:0] id; logic [c_cnt_w-1:0] len; } ph_t;
  typedef struct { int due; logic [2:0] code; } er_t;
  ph_t exp_ph[$];
  er_t exp_er[$];

  traffic_signal_monitor_if #(.CNT_W(c_cnt_w)) bus ();

  traffic_signal_monitor #(
    .CNT_W      (c_cnt_w),
    .MIN_YELLOW (3),
    .MAX_YELLOW (20),
    .EXP_PATH   (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A vector driven now is registered at the next edge and reported one edge later.
  task automatic exp_phase(input logic [1:0] id, input int len);
    ph_t e;
    e.due = cyc + 2; e.id = id; e.len = c_cnt_w'(len);
    exp_ph.push_back(e);
  endtask

  task automatic exp_err(input logic [2:0] code);
    er_t e;
    e.due = cyc + 2; e.code = code;
    exp_er.push_back(e);
  endtask

  task automatic step(input logic [3:0] car, input logic [1:0] walk,
                      input logic [1:0] path = 2'd0, input logic clr = 1'b0);
    bus.car_traffic  = car;
    bus.walk_traffic = walk;
    bus.path_index   = path;
    bus.clear_fault  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] car, input logic [1:0] walk, input int n);
    for (int i = 0; i < n; i++) step(car, walk);
  endtask

  task automatic chk_status(input string tag, input logic [7:0] cnt, input logic flt);
    chk({tag, "_err_count"}, bus.err_count, cnt);
    chk({tag, "_fault"}, bus.fault, flt);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase_done"}, bus.phase_done, 0);
    chk({tag, "_phase_id"}, bus.phase_id, 0);
    chk({tag, "_phase_len"}, bus.phase_len, 0);
    chk({tag, "_err_valid"}, bus.err_valid, 0);
    chk({tag, "_err_code"}, bus.err_code, 0);
    chk_status(tag, 8'd0, 1'b0);
  endtask

  // Scoreboard: every cycle either a due expectation is consumed or the
  // pulse must be absent.
  always @(negedge clk) begin
    ph_t p;
    er_t e;
    if (chk_en) begin
      if ((exp_ph.size() > 0) && (exp_ph[0].due == cyc)) begin
        p = exp_ph.pop_front();
        chk("phase_done", bus.phase_done, 1);
        chk("phase_id", bus.phase_id, p.id);
        chk("phase_len", bus.phase_len, p.len);
      end else begin
        chk("no_phase_done", bus.phase_done, 0);
      end
      if ((exp_er.size() > 0) && (exp_er[0].due == cyc)) begin
        e = exp_er.pop_front();
        chk("err_valid", bus.err_valid, 1);
        chk("err_code", bus.err_code, e.code);
      end else begin
        chk("no_err_valid", bus.err_valid, 0);
      end
    end
  end

  initial begin
    bus.path_index   = 2'd0;
    bus.car_traffic  = CAR_RED;
    bus.walk_traffic = WALK_STOP;
    bus.clear_fault  = 1'b0;
    rst = 1'b1;
    hold(CAR_RED, WALK_STOP, 3);
    chk_all_zero("reset");
    chk_en = 1'b1;
    rst = 1'b0;

    // T1: legal rotation
    hold(CAR_RED, WALK_STOP, 10);
    exp_phase(PH_RED, 10);
    hold(CAR_GREEN, WALK_STOP, 8);
    exp_phase(PH_GREEN, 8);
    hold(CAR_YELLOW, WALK_STOP, 4);
    exp_phase(PH_YELLOW, 4);
    hold(CAR_RED_LEFT, WALK_GO, 3);
    chk_status("t1", 8'd0, 1'b0);

    // T2: walk green against green car lamps
    exp_phase(PH_RED, 3);
    hold(CAR_GREEN_LEFT, WALK_STOP, 2);
    exp_err(ERR_CONFLICT);
    step(CAR_GREEN, WALK_GO);
    hold(CAR_GREEN, WALK_STOP, 2);
    chk_status("t2", 8'd1, 1'b1);

    // T3: yellow skipped, then clear
    exp_phase(PH_GREEN, 5);
    exp_err(ERR_SEQ);
    hold(CAR_RED, WALK_STOP, 4);
    chk_status("t3", 8'd2, 1'b1);
    step(CAR_RED, WALK_STOP, 2'd0, 1'b1);
    chk_status("t3_clear", 8'd0, 1'b0);

    // T4: yellow too short, then too long
    exp_phase(PH_RED, 5);
    hold(CAR_GREEN, WALK_STOP, 3);
    exp_phase(PH_GREEN, 3);
    hold(CAR_YELLOW, WALK_STOP, 2);
    exp_phase(PH_YELLOW, 2);
    exp_err(ERR_YEL_SHORT);
    hold(CAR_RED, WALK_STOP, 4);
    chk_status("t4_short", 8'd1, 1'b1);
    exp_phase(PH_RED, 4);
    hold(CAR_GREEN, WALK_STOP, 3);
    exp_phase(PH_GREEN, 3);
    hold(CAR_YELLOW, WALK_STOP, 20);
    exp_err(ERR_YEL_LONG);
    step(CAR_YELLOW, WALK_STOP);
    hold(CAR_YELLOW, WALK_STOP, 4);
    exp_phase(PH_YELLOW, 25);
    hold(CAR_RED, WALK_STOP, 3);
    chk_status("t4_long", 8'd2, 1'b1);

    // T5: illegal codes and recovery without a sequence error
    exp_phase(PH_RED, 3);
    exp_err(ERR_ILLEGAL_CAR);
    step(4'b0110, WALK_STOP);
    exp_err(ERR_ILLEGAL_WALK);
    step(CAR_RED, 2'b11);
    exp_phase(PH_UNKNOWN, 2);
    hold(CAR_RED, WALK_STOP, 3);
    chk_status("t5", 8'd4, 1'b1);

    // Error reported on the same edge as clear_fault
    exp_phase(PH_RED, 3);
    exp_err(ERR_ILLEGAL_WALK);
    step(CAR_RED, 2'b11);
    exp_phase(PH_UNKNOWN, 1);
    step(CAR_RED, WALK_STOP, 2'd0, 1'b1);
    chk_status("clear_vs_err", 8'd1, 1'b1);
    hold(CAR_RED, WALK_STOP, 2);

    // T6: other approaches are ignored and freeze the timer
    for (int i = 0; i < 3; i++) step(CAR_GREEN, WALK_GO, 2'd1);
    step(4'b1111, 2'b11, 2'd2);
    hold(CAR_RED, WALK_STOP, 2);
    exp_phase(PH_RED, 5);
    hold(CAR_GREEN, WALK_STOP, 3);
    chk_status("t6_gate", 8'd1, 1'b1);

    // Reset in the middle of GREEN aborts the phase silently
    rst = 1'b1;
    hold(CAR_GREEN, WALK_STOP, 2);
    chk_all_zero("t6_rst");
    rst = 1'b0;
    hold(CAR_RED, WALK_STOP, 5);
    chk_status("t6_after", 8'd0, 1'b0);

    chk("phase_queue_empty", exp_ph.size(), 0);
    chk("err_queue_empty", exp_er.size(), 0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
`default_nettype wire
